// File: rtl/dsd_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state codes (common with the divider) and op-mode decode.
package dsd_multiplier_pkg;

  typedef enum logic [2:0] {
    MUL   = 3'd3,
    IDLE  = 3'd4,
    DONE  = 3'd5,
    DONE2 = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OP_UU = 2'd0,
    OP_SU = 2'd1,
    OP_SS = 2'd2
  } op_mode_t;

  // ss outranks su
  function automatic op_mode_t op_decode(input logic ss, input logic su);
    if (ss)      return OP_SS;
    else if (su) return OP_SU;
    else         return OP_UU;
  endfunction

endpackage

// File: rtl/dsd_negate.sv
// N-bit conditional two's-complement negate.
module dsd_negate #(
  parameter int N = 160
) (
  input  logic         neg,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  assign q = neg ? (~d + 1'b1) : d;

endmodule

// File: rtl/dsd_multiplier.sv
// Iterative radix-2 shift-add multiplier producing a 2*WID-bit product; ld/done/idle handshake matches the divider.
module dsd_multiplier
  import dsd_multiplier_pkg::*;
#(
  parameter int WID = 80
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ld,
  input  logic           abort,
  input  logic           ss,
  input  logic           su,
  input  logic           isMuli,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  input  logic [WID-1:0] imm,
  output logic [WID-1:0] phi,
  output logic [WID-1:0] plo,
  output logic           done,
  output logic           idle
);

  state_t         state, state_nxt;
  logic [WID-1:0] acc, q, mb;
  logic           so;
  logic [7:0]     cnt;

  logic [WID-1:0]   sel, a_abs, sel_abs, ma_n, mb_n;
  logic             so_n;
  logic [WID:0]     sum;
  logic [2*WID-1:0] prod;

  // operand conditioning: magnitudes plus result sign
  always_comb begin
    sel     = isMuli ? imm : b;
    a_abs   = a[WID-1]   ? (~a + 1'b1)   : a;
    sel_abs = sel[WID-1] ? (~sel + 1'b1) : sel;
    ma_n    = a;
    mb_n    = sel;
    so_n    = 1'b0;
    case (op_decode(ss, su))
      OP_SS: begin
        ma_n = a_abs;
        mb_n = sel_abs;
        so_n = a[WID-1] ^ sel[WID-1];
      end
      OP_SU: begin
        ma_n = a_abs;
        so_n = a[WID-1];
      end
      default: ;
    endcase
  end

  // carry out of the add is kept and shifted into acc
  assign sum = {1'b0, acc} + {1'b0, (q[0] ? mb : '0)};

  dsd_negate #(.N(2*WID)) u_neg (
    .neg (so),
    .d   ({acc, q}),
    .q   (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = ld ? MUL : IDLE;
      MUL:     state_nxt = abort ? IDLE : ((cnt == 8'd0) ? DONE : MUL);
      DONE:    state_nxt = DONE2;
      DONE2:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    idle = (state == IDLE);
    done = (state == DONE) || (state == DONE2) || ((state == IDLE) && !ld);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      q   <= '0;
      mb  <= '0;
      so  <= 1'b0;
      cnt <= 8'd0;
      phi <= '0;
      plo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld) begin
            acc <= '0;
            q   <= ma_n;
            mb  <= mb_n;
            so  <= so_n;
            cnt <= 8'(WID);
          end else if (abort) begin
            cnt <= 8'd0;
          end
        end
        MUL: begin
          if (abort) begin
            cnt <= 8'd0;
          end else if (cnt != 8'd0) begin
            acc <= sum[WID:1];
            q   <= {sum[0], q[WID-1:1]};
            cnt <= cnt - 8'd1;
          end else begin
            {phi, plo} <= prod;
          end
        end
        default: begin
          if (abort) cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsd_multiplier.sv
// Self-checking bench for dsd_multiplier (WID=64): directed table, randomized ops vs a wide-arithmetic model, control corners.
module tb_dsd_multiplier;

  localparam int W   = 64;
  localparam int LAT = W + 2;   // edges counted from (and including) the ld-sampling edge
  localparam int LIM = 200;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ld = 1'b0, abort = 1'b0, ss = 1'b0, su = 1'b0, isMuli = 1'b0;
  logic [W-1:0] a = '0, b = '0, imm = '0;
  logic [W-1:0] phi, plo;
  logic         done, idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsd_multiplier #(.WID(W)) dut (
    .clk(clk), .rst_n(rst_n), .ld(ld), .abort(abort), .ss(ss), .su(su), .isMuli(isMuli),
    .a(a), .b(b), .imm(imm), .phi(phi), .plo(plo), .done(done), .idle(idle)
  );

  typedef struct {
    logic         v_ss, v_su, v_mi;
    logic [W-1:0] v_a, v_b, v_imm;
    logic [W-1:0] e_hi, e_lo;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // reference: sign/zero extend to 2W bits and multiply modulo 2^(2W)
  function automatic logic [127:0] ref_mul(input logic m_ss, input logic m_su,
                                           input logic [W-1:0] ma, input logic [W-1:0] ms);
    logic [127:0] ae, be;
    ae = (m_ss || m_su) ? {{W{ma[W-1]}}, ma} : {{W{1'b0}}, ma};
    be = m_ss ? {{W{ms[W-1]}}, ms} : {{W{1'b0}}, ms};
    return ae * be;
  endfunction

  // start an op and wait for done; pulse_at>0 re-pulses ld (with junk operands) at that count
  task automatic run_op(input logic o_ss, input logic o_su, input logic o_mi,
                        input logic [W-1:0] oa, input logic [W-1:0] ob, input logic [W-1:0] oi,
                        input int pulse_at, output int lat);
    @(negedge clk);
    ss = o_ss; su = o_su; isMuli = o_mi; a = oa; b = ob; imm = oi; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    lat = 1;
    while (!done && lat < LIM) begin
      if (pulse_at != 0 && lat == pulse_at) begin
        ld = 1'b1; a = 64'd99; b = 64'd77;
      end else begin
        ld = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    ld = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!idle && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("return_to_idle", {127'd0, idle}, 128'd1);
  endtask

  initial begin
    int lat;
    logic [127:0] exp;
    logic         r_ss, r_su, r_mi;
    logic [W-1:0] ra, rb, ri;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 64'd10005, 64'd27, 64'd0, 64'd0, 64'd270135};
    vecs[1] = '{1'b1, 1'b0, 1'b0, -64'sd7, 64'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[2] = '{1'b0, 1'b1, 1'b0, -64'sd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, -64'sd1, 64'd0, 64'd0, 64'h8000_0000_0000_0000};

    #12;
    chk("rst_phi",  {64'd0, phi}, 128'd0);
    chk("rst_plo",  {64'd0, plo}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd1);
    chk("rst_idle", {127'd0, idle}, 128'd1);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].v_ss, vecs[i].v_su, vecs[i].v_mi, vecs[i].v_a, vecs[i].v_b, vecs[i].v_imm, 0, lat);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(LAT));
      chk($sformatf("vec%0d_phi", i), {64'd0, phi}, {64'd0, vecs[i].e_hi});
      chk($sformatf("vec%0d_plo", i), {64'd0, plo}, {64'd0, vecs[i].e_lo});
      chk($sformatf("vec%0d_idle_in_done", i), {127'd0, idle}, 128'd0);
      wait_idle();
    end

    for (int i = 0; i < 24; i++) begin
      r_ss = 1'($urandom); r_su = 1'($urandom); r_mi = 1'($urandom);
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; ri = {$urandom, $urandom};
      if (i % 6 == 0) ra = 64'h8000_0000_0000_0000;
      if (i % 7 == 3) rb = 64'd0;
      run_op(r_ss, r_su, r_mi, ra, rb, ri, 0, lat);
      exp = ref_mul(r_ss, r_su, ra, r_mi ? ri : rb);
      chk($sformatf("rnd%0d_latency", i), 128'(lat), 128'(LAT));
      chk($sformatf("rnd%0d_product", i), {phi, plo}, exp);
      wait_idle();
    end

    // ld re-pulsed mid-MUL is ignored
    run_op(1'b0, 1'b0, 1'b0, 64'd5, 64'd7, 64'd0, 10, lat);
    chk("ld_ignored_latency", 128'(lat), 128'(LAT));
    chk("ld_ignored_product", {phi, plo}, 128'd35);
    wait_idle();

    // abort when cnt reaches 30 (34 edges after ld sampled)
    @(negedge clk);
    ss = 1'b0; su = 1'b0; isMuli = 1'b0; a = 64'd3; b = 64'd9; ld = 1'b1;
    @(posedge clk); #1 ld = 1'b0;
    repeat (34) @(posedge clk);
    #1;
    chk("busy_before_abort", {127'd0, idle}, 128'd0);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_idle", {127'd0, idle}, 128'd1);
    chk("abort_keeps_result", {phi, plo}, 128'd35);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_late_result", {phi, plo}, 128'd35);

    // abort and ld together in IDLE: ld wins
    @(negedge clk);
    a = 64'd11; b = 64'd13; ld = 1'b1; abort = 1'b1;
    @(posedge clk); #1 ld = 1'b0; abort = 1'b0;
    chk("abort_ld_started", {127'd0, idle}, 128'd0);
    lat = 1;
    while (!done && lat < LIM) begin @(posedge clk); #1; lat++; end
    chk("abort_ld_product", {phi, plo}, 128'd143);
    wait_idle();

    // ld held through DONE2->IDLE restarts immediately
    @(negedge clk);
    a = 64'd2; b = 64'd3; ld = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!done && lat < LIM) begin @(posedge clk); #1; lat++; end
    chk("held_ld_latency", 128'(lat), 128'(LAT));
    chk("held_ld_product", {phi, plo}, 128'd6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("held_ld_idle", {127'd0, idle}, 128'd1);
    chk("held_ld_not_done", {127'd0, done}, 128'd0);
    @(posedge clk); #1;
    chk("held_ld_restart", {127'd0, idle}, 128'd0);
    ld = 1'b0;

    // async reset mid-MUL
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("amid_rst_phi", {64'd0, phi}, 128'd0);
    chk("amid_rst_plo", {64'd0, plo}, 128'd0);
    chk("amid_rst_idle", {127'd0, idle}, 128'd1);
    chk("amid_rst_done", {127'd0, done}, 128'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", {127'd0, idle}, 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
